// File: rtl/spi_target_regs.sv
// SPI mode-0 target with a 16-entry register map; all SPI pins are
// oversampled in the clk domain and decoded by a small frame FSM.
module spi_target_regs #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  RESET_VAL   = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] reg_in,
    output logic [7:0] reg0_out,
    output logic       wr_stb,
    output logic [3:0] wr_addr,
    output logic       frame_done
);

    typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_dly_q, cs_dly_q;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  out_sr_q, out_sr_d;
    logic [3:0]  addr_q, addr_d;
    logic        wr_stb_q, wr_stb_d;
    logic [3:0]  wr_addr_q, wr_addr_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  mem_q [0:14];
    logic [7:0]  mem_d [0:14];

    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [7:0] byte_in;
    logic [3:0] ld_addr;
    logic [7:0] ld_data;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign cs_rise   = cs_s & ~cs_dly_q;
    assign cs_fall   = ~cs_s & cs_dly_q;
    assign byte_in   = {shift_q[6:0], mosi_s};

    assign miso       = (state_q == RD) & out_sr_q[7];
    assign miso_oe    = ~cs_s;
    assign reg0_out   = mem_q[0];
    assign wr_stb     = wr_stb_q;
    assign wr_addr    = wr_addr_q;
    assign frame_done = frame_done_q;

    // The command byte supplies the first read address before addr_q holds it.
    always_comb begin
        ld_addr = (state_q == CMD) ? byte_in[3:0] : addr_q;
        ld_data = reg_in;
        for (int i = 0; i < 15; i++) begin
            if (ld_addr == i[3:0]) ld_data = mem_q[i];
        end
    end

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        out_sr_d     = out_sr_q;
        addr_d       = addr_q;
        wr_stb_d     = 1'b0;
        wr_addr_d    = wr_addr_q;
        frame_done_d = 1'b0;
        mem_d        = mem_q;

        if (cs_rise) begin
            state_d      = IDLE;
            bit_cnt_d    = 3'd0;
            shift_d      = 8'h00;
            out_sr_d     = 8'h00;
            frame_done_d = (state_q != IDLE);
        end else if (state_q == IDLE) begin
            if (cs_fall) begin
                state_d   = CMD;
                bit_cnt_d = 3'd0;
                shift_d   = 8'h00;
            end
        end else if (sclk_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                case (state_q)
                    CMD: begin
                        addr_d = byte_in[3:0];
                        if (byte_in[7]) begin
                            state_d  = RD;
                            out_sr_d = ld_data;
                            addr_d   = byte_in[3:0] + 4'd1;
                        end else begin
                            state_d = WR;
                        end
                    end
                    WR: begin
                        wr_stb_d  = 1'b1;
                        wr_addr_d = addr_q;
                        for (int i = 0; i < 15; i++) begin
                            if (addr_q == i[3:0]) mem_d[i] = byte_in;
                        end
                        addr_d = addr_q + 4'd1;
                    end
                    RD: begin
                        out_sr_d = ld_data;
                        addr_d   = addr_q + 4'd1;
                    end
                    default: ;
                endcase
            end
        end else if (sclk_fall && state_q == RD && bit_cnt_q != 3'd0) begin
            // The fall right after a load keeps bit7 up for the next rise.
            out_sr_d = {out_sr_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q  <= '0;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            sclk_dly_q   <= 1'b0;
            cs_dly_q     <= 1'b1;
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            out_sr_q     <= 8'h00;
            addr_q       <= 4'd0;
            wr_stb_q     <= 1'b0;
            wr_addr_q    <= 4'd0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 15; i++) mem_q[i] <= RESET_VAL;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_dly_q   <= sclk_s;
            cs_dly_q     <= cs_s;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            out_sr_q     <= out_sr_d;
            addr_q       <= addr_d;
            wr_stb_q     <= wr_stb_d;
            wr_addr_q    <= wr_addr_d;
            frame_done_q <= frame_done_d;
            mem_q        <= mem_d;
        end
    end

endmodule

// File: doc/spi_target_regs.md
SPI_TARGET_REGS -- requirements
Module: spi_target_regs

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchroniser flops on sclk, cs_n and mosi; legal range 2..3.
REQ-002 Parameter RESET_VAL, default 8'h00: reset value of every register-file entry.
REQ-003 clk  input  1  single system clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sclk  input  1  SPI serial clock from the master, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-006 cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-007 mosi  input  1  SPI master-out data, MSB first.
REQ-008 miso  output  1  SPI master-in data, MSB first.
REQ-009 miso_oe  output  1  high while the synchronised cs_n is low.
REQ-010 reg_in  input  8  read-only status byte returned at address 4'hF.
REQ-011 reg0_out  output  8  live contents of register 0.
REQ-012 wr_stb  output  1  one-cycle pulse on each completed register write.
REQ-013 wr_addr  output  4  address of the write flagged by wr_stb; holds its value between pulses.
REQ-014 frame_done  output  1  one-cycle pulse when cs_n deasserts after a frame.

Function
REQ-015 sclk, cs_n and mosi each SHALL pass SYNC_STAGES flops; edges SHALL be detected from the last stage against a further delay flop.
REQ-016 Frame: cs_n fall, command byte, then zero or more data bytes; cs_n rise ends the frame.
REQ-017 Command byte: bit7 = 1 read, 0 write; bits 6:4 ignored; bits 3:0 start address.
REQ-018 FSM states: IDLE, CMD, WR, RD. IDLE->CMD on cs_n fall. CMD->WR or CMD->RD after the 8th sampled bit. Any state->IDLE on cs_n rise.
REQ-019 mosi SHALL be sampled on each detected sclk rising edge into an 8-bit shift register; a 3-bit bit counter SHALL count edges and wrap 7->0.
REQ-020 WR: on the 8th bit of each data byte, write mem[addr]. Assert wr_stb for 1 cycle with wr_addr=addr. Then addr = addr+1 mod 16.
REQ-021 Writes to address 4'hF SHALL be discarded; wr_stb SHALL still pulse with wr_addr=4'hF.
REQ-022 RD: on the 8th rising edge of the command byte, and of each data byte, load the output shift register with the byte at addr, then increment addr mod 16.
REQ-023 The byte at address 4'hF is reg_in, sampled at the load cycle. All other addresses return mem[addr].
REQ-024 miso SHALL present bit7 of the loaded byte immediately on load, and SHALL shift to the next bit on each detected sclk falling edge.
REQ-025 miso SHALL be 0 in IDLE, CMD and WR states.
REQ-026 Pin-to-effect latency SHALL be SYNC_STAGES+1 clk cycles for both the register write and the miso update.
REQ-027 sclk high time and low time SHALL each be at least 2*(SYNC_STAGES+1) clk periods; slower sclk is unrestricted.
REQ-028 cs_n rise mid-byte SHALL discard the partial byte: no write, no wr_stb, bit counter cleared.
REQ-029 frame_done SHALL pulse for 1 cycle on every detected cs_n rise that follows a detected cs_n fall, including aborted frames.
REQ-030 A cs_n fall in the same cycle as an sclk edge SHALL ignore that sclk edge.
REQ-031 Address wrap: a burst continuing past 4'hF SHALL continue at 4'h0.
REQ-032 reg0_out SHALL equal mem[0] at all times.

Reset
REQ-033 While rst_n is low, these SHALL be 0: FSM (IDLE), counters, shift registers, miso, miso_oe, wr_stb, wr_addr, frame_done.
REQ-034 While rst_n is low, mem[0..14] SHALL be RESET_VAL, so reg0_out=RESET_VAL.
REQ-035 Synchroniser flops SHALL reset to idle levels: sclk 0, cs_n 1, mosi 0.
REQ-036 Reset asserted mid-frame SHALL abort the frame without a write. After release, the first action SHALL be a fresh cs_n fall.

Verification
REQ-037 Write single: clk period 10 ns, sclk 160 ns. Frame cmd 8'h03, data 8'hA5 -> mem[3]=A5, one wr_stb with wr_addr=3, then frame_done.
REQ-038 Burst write with wrap: cmd 8'h0E, data 11,22,33. Then -> mem[E]=11; address F discarded; mem[0]=33, so reg0_out=33. Three wr_stb pulses with wr_addr E,F,0.
REQ-039 Burst read: after REQ-038, reg_in=8'h5C, cmd 8'h8E, 3 data bytes -> master samples 11,5C,33; miso=0 during the command byte.
REQ-040 Abort: cmd 8'h02, then 5 data bits, then cs_n high -> mem[2] unchanged, no wr_stb, frame_done pulses. The next frame decodes correctly.
REQ-041 Async reset: rst_n low mid-read for 3 cycles -> all outputs 0, reg0_out=RESET_VAL. A new write frame then succeeds.
REQ-042 Edge timing: sclk half-period exactly 6 clk at SYNC_STAGES=2 -> all bits correct. Also check wr_stb occurs 3 clk after the pin-level 8th rising edge.
